// File: rtl/pc_branch_unit_pkg.sv
// Shared encodings for the fetch-PC / branch-resolution slice:
// branch types, 2-bit predictor states and BHT index sizing.
package pc_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic int unsigned bht_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_branch_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational
// read port, one synchronous write (train) port, no read-during-write bypass.
module bht_2bit
    import pc_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned IDX_W     = bht_idx_w(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] r_ctr [BHT_DEPTH];
    logic [1:0] w_cur;
    logic [1:0] w_nxt;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_wr_idx];

    always_comb begin
        w_nxt = w_cur;
        if (i_wr_taken) begin
            if (w_cur != CTR_ST) w_nxt = w_cur + 2'd1;
        end else begin
            if (w_cur != CTR_SNT) w_nxt = w_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) r_ctr[i] <= CTR_WNT;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_nxt;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with prioritised redirect (exception, JR, execute
// mispredict, decode-predicted branch/jump), BHT training and mispredict count.
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     BHT_DEPTH  = 16,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Exception,
    input  logic            Dec_valid,
    input  logic [XLEN-1:0] Dec_pc,
    input  logic            Dec_branch,
    input  logic            Dec_jump,
    input  logic [XLEN-1:0] Dec_target,
    input  logic            Ex_valid,
    input  logic [2:0]      Ex_type,
    input  logic [XLEN-1:0] Ex_a,
    input  logic [XLEN-1:0] Ex_b,
    input  logic [XLEN-1:0] Ex_pc,
    input  logic [XLEN-1:0] Ex_target,
    input  logic            Ex_pred_taken,
    input  logic            Ex_jr,
    output logic [XLEN-1:0] PC,
    output logic            Pred_taken,
    output logic            Flush_IF,
    output logic            Flush_ID,
    output logic [15:0]     Mispredict_cnt
);

    localparam int unsigned IDX_W = bht_idx_w(BHT_DEPTH);

    logic [XLEN-1:0]  r_pc;
    logic [15:0]      r_mp_cnt;
    logic [1:0]       w_dec_ctr;
    logic             w_cond;
    logic             w_ex_taken;
    logic             w_ex_branch;
    logic             w_mispredict;
    logic             w_bht_wr;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_flush_if;
    logic             w_flush_id;
    logic [IDX_W-1:0] w_dec_idx;
    logic [IDX_W-1:0] w_ex_idx;

    assign w_dec_idx = Dec_pc[IDX_W+1:2];
    assign w_ex_idx  = Ex_pc[IDX_W+1:2];

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_dec_idx),
        .o_rd_ctr   (w_dec_ctr),
        .i_wr_en    (w_bht_wr),
        .i_wr_idx   (w_ex_idx),
        .i_wr_taken (w_ex_taken)
    );

    // Zero comparisons are signed and look only at Ex_a.
    always_comb begin
        w_cond = 1'b0;
        case (br_type_e'(Ex_type))
            BR_BEQ:  w_cond = (Ex_a == Ex_b);
            BR_BNE:  w_cond = (Ex_a != Ex_b);
            BR_BLEZ: w_cond = ($signed(Ex_a) <= 0);
            BR_BGTZ: w_cond = ($signed(Ex_a) > 0);
            BR_BLTZ: w_cond = ($signed(Ex_a) < 0);
            BR_BGEZ: w_cond = ($signed(Ex_a) >= 0);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_ex_branch  = Ex_valid & (Ex_type != BR_NONE);
    assign w_ex_taken   = Ex_valid & w_cond;
    assign w_mispredict = w_ex_branch & (w_ex_taken != Ex_pred_taken);
    assign w_bht_wr     = w_ex_branch & ~Exception;
    assign Pred_taken   = Dec_valid & Dec_branch & w_dec_ctr[1];

    always_comb begin
        w_next_pc  = r_pc + XLEN'(4);
        w_flush_if = 1'b0;
        w_flush_id = 1'b0;
        if (Exception) begin
            w_next_pc  = EXC_VECTOR;
            w_flush_if = 1'b1;
            w_flush_id = 1'b1;
        end else if (Ex_valid & Ex_jr) begin
            w_next_pc  = Ex_a;
            w_flush_if = 1'b1;
            w_flush_id = 1'b1;
        end else if (w_mispredict) begin
            w_next_pc  = w_ex_taken ? Ex_target : Ex_pc + XLEN'(4);
            w_flush_if = 1'b1;
            w_flush_id = 1'b1;
        end else if (~Stall & Dec_valid & (Dec_jump | Pred_taken)) begin
            w_next_pc  = Dec_target;
            w_flush_if = 1'b1;
        end else if (Stall) begin
            w_next_pc  = r_pc;
        end
    end

    assign Flush_IF = w_flush_if & ~rst;
    assign Flush_ID = w_flush_id & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_mp_cnt <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_mispredict & ~Exception & (r_mp_cnt != '1))
                r_mp_cnt <= r_mp_cnt + 16'd1;
        end
    end

    assign PC             = r_pc;
    assign Mispredict_cnt = r_mp_cnt;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed-vector bench: each cycle's hand-computed expectations go into a
// queue; a negedge monitor pops one per cycle and compares the DUT outputs.
module tb_pc_branch_unit;

    typedef struct {
        logic        rst, stall, exc, dv;
        logic [31:0] dpc;
        logic        dbr, djmp;
        logic [31:0] dtgt;
        logic        ev;
        logic [2:0]  et;
        logic [31:0] ea, eb, epc, etgt;
        logic        epred, ejr;
    } in_t;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        pred, fif, fid;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, Stall, Exception, Dec_valid, Dec_branch, Dec_jump;
    logic [31:0] Dec_pc, Dec_target;
    logic        Ex_valid, Ex_pred_taken, Ex_jr;
    logic [2:0]  Ex_type;
    logic [31:0] Ex_a, Ex_b, Ex_pc, Ex_target;
    logic [31:0] PC;
    logic        Pred_taken, Flush_IF, Flush_ID;
    logic [15:0] Mispredict_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_id = 0;

    always #5 clk = ~clk;

    pc_branch_unit #(
        .XLEN       (32),
        .BHT_DEPTH  (16),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0180)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Stall          (Stall),
        .Exception      (Exception),
        .Dec_valid      (Dec_valid),
        .Dec_pc         (Dec_pc),
        .Dec_branch     (Dec_branch),
        .Dec_jump       (Dec_jump),
        .Dec_target     (Dec_target),
        .Ex_valid       (Ex_valid),
        .Ex_type        (Ex_type),
        .Ex_a           (Ex_a),
        .Ex_b           (Ex_b),
        .Ex_pc          (Ex_pc),
        .Ex_target      (Ex_target),
        .Ex_pred_taken  (Ex_pred_taken),
        .Ex_jr          (Ex_jr),
        .PC             (PC),
        .Pred_taken     (Pred_taken),
        .Flush_IF       (Flush_IF),
        .Flush_ID       (Flush_ID),
        .Mispredict_cnt (Mispredict_cnt)
    );

    function automatic in_t idle();
        in_t v;
        v.rst = 0; v.stall = 0; v.exc = 0; v.dv = 0; v.dpc = '0; v.dbr = 0;
        v.djmp = 0; v.dtgt = '0; v.ev = 0; v.et = 3'd0; v.ea = '0; v.eb = '0;
        v.epc = '0; v.etgt = '0; v.epred = 0; v.ejr = 0;
        return v;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic pred,
                                input logic fif, input logic fid, input logic [15:0] cnt);
        exp_t e;
        e.id = 0; e.pc = pc; e.pred = pred; e.fif = fif; e.fid = fid; e.cnt = cnt;
        return e;
    endfunction

    task automatic apply(input in_t v);
        rst = v.rst; Stall = v.stall; Exception = v.exc; Dec_valid = v.dv;
        Dec_pc = v.dpc; Dec_branch = v.dbr; Dec_jump = v.djmp; Dec_target = v.dtgt;
        Ex_valid = v.ev; Ex_type = v.et; Ex_a = v.ea; Ex_b = v.eb; Ex_pc = v.epc;
        Ex_target = v.etgt; Ex_pred_taken = v.epred; Ex_jr = v.ejr;
    endtask

    task automatic drive(input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        apply(v);
        vec_id++;
        e.id = vec_id;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("PC",             e.id, PC,                     e.pc);
            chk("Pred_taken",     e.id, {31'd0, Pred_taken},    {31'd0, e.pred});
            chk("Flush_IF",       e.id, {31'd0, Flush_IF},      {31'd0, e.fif});
            chk("Flush_ID",       e.id, {31'd0, Flush_ID},      {31'd0, e.fid});
            chk("Mispredict_cnt", e.id, {16'd0, Mispredict_cnt}, {16'd0, e.cnt});
        end
    end

    initial begin
        in_t v;
        v = idle(); v.rst = 1;
        apply(v);

        // V1: reset beats exception, execute redirect and decode jump
        v = idle(); v.rst = 1; v.exc = 1; v.dv = 1; v.djmp = 1; v.dtgt = 32'h600;
        v.ev = 1; v.et = 3'd1; v.ea = 1; v.eb = 2; v.epred = 1; v.epc = 32'h40;
        drive(v, mk(32'h0, 0, 0, 0, 0));
        // V2-V5: sequential fetch
        v = idle();
        drive(v, mk(32'h0, 0, 0, 0, 0));
        drive(v, mk(32'h4, 0, 0, 0, 0));
        drive(v, mk(32'h8, 0, 0, 0, 0));
        drive(v, mk(32'hC, 0, 0, 0, 0));
        // V6: BEQ taken, predicted not taken
        v = idle(); v.ev = 1; v.et = 3'd1; v.ea = 5; v.eb = 5; v.epc = 32'h40; v.etgt = 32'h80;
        drive(v, mk(32'h10, 0, 1, 1, 0));
        // V7: decode branch at 0x40 now predicted taken
        v = idle(); v.dv = 1; v.dbr = 1; v.dpc = 32'h40; v.dtgt = 32'h80;
        drive(v, mk(32'h80, 1, 1, 0, 1));
        v = idle();
        drive(v, mk(32'h80, 0, 0, 0, 1));
        // V9-V12: BLTZ a=-1 trains idx1 up to saturation, observed on decode
        v = idle(); v.ev = 1; v.et = 3'd5; v.ea = 32'hFFFF_FFFF; v.epred = 1; v.epc = 32'h44;
        v.etgt = 32'h900; v.dv = 1; v.dbr = 1; v.dpc = 32'h44; v.dtgt = 32'h200;
        drive(v, mk(32'h84,  0, 0, 0, 1));
        drive(v, mk(32'h88,  1, 1, 0, 1));
        drive(v, mk(32'h200, 1, 1, 0, 1));
        drive(v, mk(32'h200, 1, 1, 0, 1));
        // V13: one not-taken step from saturated 11 -> 10
        v = idle(); v.ev = 1; v.et = 3'd5; v.ea = 0; v.epred = 0; v.epc = 32'h44;
        drive(v, mk(32'h200, 0, 0, 0, 1));
        v = idle(); v.dv = 1; v.dbr = 1; v.dpc = 32'h44; v.dtgt = 32'h300;
        drive(v, mk(32'h204, 1, 1, 0, 1));
        // V15: BGEZ on most-negative value, predicted taken -> Ex_pc+4
        v = idle(); v.ev = 1; v.et = 3'd6; v.ea = 32'h8000_0000; v.epred = 1;
        v.epc = 32'h48; v.etgt = 32'h999;
        drive(v, mk(32'h300, 0, 1, 1, 1));
        v = idle();
        drive(v, mk(32'h4C, 0, 0, 0, 2));
        // V17: exception with simultaneous mispredict and decode jump
        v = idle(); v.exc = 1; v.ev = 1; v.et = 3'd1; v.ea = 1; v.eb = 2; v.epred = 1;
        v.epc = 32'h40; v.etgt = 32'h500; v.dv = 1; v.djmp = 1; v.dpc = 32'h10; v.dtgt = 32'h600;
        drive(v, mk(32'h50, 0, 1, 1, 2));
        // V18: idx0 still weakly taken, so no training happened under exception
        v = idle(); v.dv = 1; v.dbr = 1; v.dpc = 32'h40; v.dtgt = 32'h700;
        drive(v, mk(32'h180, 1, 1, 0, 2));
        // V19: stall suppresses decode jump
        v = idle(); v.stall = 1; v.dv = 1; v.djmp = 1; v.dtgt = 32'h800;
        drive(v, mk(32'h700, 0, 0, 0, 2));
        // V20: stall does not block execute mispredict
        v = idle(); v.stall = 1; v.ev = 1; v.et = 3'd2; v.ea = 3; v.eb = 3; v.epred = 1;
        v.epc = 32'h60; v.etgt = 32'h900;
        drive(v, mk(32'h700, 0, 1, 1, 2));
        // V21-V22: JR redirects, second one to the top of the address space
        v = idle(); v.ev = 1; v.ejr = 1; v.ea = 32'h1234;
        drive(v, mk(32'h64, 0, 1, 1, 3));
        v.ea = 32'hFFFF_FFFC;
        drive(v, mk(32'h1234, 0, 1, 1, 3));
        v = idle();
        drive(v, mk(32'hFFFF_FFFC, 0, 0, 0, 3));
        drive(v, mk(32'h0, 0, 0, 0, 3));
        // V25: reserved type never taken; Ex_pc+4 wraps to 0
        v = idle(); v.ev = 1; v.et = 3'd7; v.ea = 9; v.eb = 9; v.epred = 1; v.epc = 32'hFFFF_FFFC;
        drive(v, mk(32'h4, 0, 1, 1, 3));
        v = idle();
        drive(v, mk(32'h0, 0, 0, 0, 4));
        // V27: BLEZ a=0 taken, predicted not taken
        v = idle(); v.ev = 1; v.et = 3'd3; v.ea = 0; v.epred = 0; v.epc = 32'h70; v.etgt = 32'h3000;
        drive(v, mk(32'h4, 0, 1, 1, 4));
        // V28: BGTZ a=0 not taken, correctly predicted
        v = idle(); v.ev = 1; v.et = 3'd4; v.ea = 0; v.epred = 0; v.epc = 32'h74;
        drive(v, mk(32'h3000, 0, 0, 0, 5));
        // V29: invalid execute slot is ignored
        v = idle(); v.ev = 0; v.et = 3'd1; v.ea = 1; v.eb = 1; v.epred = 0; v.etgt = 32'h5000;
        drive(v, mk(32'h3004, 0, 0, 0, 5));
        // V30: reset mid-redirect, flushes held low
        v = idle(); v.rst = 1; v.exc = 1;
        drive(v, mk(32'h3008, 0, 0, 0, 5));
        // V31: counters back to weakly not taken after reset
        v = idle(); v.dv = 1; v.dbr = 1; v.dpc = 32'h44; v.dtgt = 32'h200;
        drive(v, mk(32'h0, 0, 0, 0, 0));

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and operand width.
REQ-002 Parameter BHT_DEPTH, default 16: number of 2-bit predictor counters; a power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-004 Parameter EXC_VECTOR, default 32'h0000_0180: exception redirect target.
REQ-005 Ports, in order (name, direction, width, meaning):
  clk  in  1  the single clock; all state on rising edge
  rst  in  1  synchronous, active-high reset
  Stall  in  1  hold PC, suppress decode redirect
  Exception  in  1  redirect to EXC_VECTOR
  Dec_valid  in  1  decode-stage instruction valid
  Dec_pc  in  XLEN  decode-stage instruction PC
  Dec_branch  in  1  decode instruction is a conditional branch
  Dec_jump  in  1  decode instruction is J/JAL
  Dec_target  in  XLEN  branch/jump target computed in decode
  Ex_valid  in  1  execute-stage instruction valid
  Ex_type  in  3  branch type (package encoding)
  Ex_a, Ex_b  in  XLEN  rs and rt operand values
  Ex_pc  in  XLEN  execute-stage instruction PC
  Ex_target  in  XLEN  branch target
  Ex_pred_taken  in  1  prediction carried down from decode
  Ex_jr  in  1  JR; Ex_a is the target
  PC  out  XLEN  registered fetch PC
  Pred_taken  out  1  combinational BHT prediction for Dec_pc
  Flush_IF  out  1  squash fetch stage
  Flush_ID  out  1  squash decode stage
  Mispredict_cnt  out  16  saturating count of mispredictions

Function
REQ-006 Ex_type encodings: 0 NONE, 1 BEQ (a==b), 2 BNE (a!=b), 3 BLEZ (a<=0), 4 BGTZ (a>0), 5 BLTZ (a<0), 6 BGEZ (a>=0), 7 reserved (not taken). Zero comparisons are signed, on Ex_a only.
REQ-007 BHT index = pc[log2(BHT_DEPTH)+1:2].
REQ-008 Pred_taken = Dec_valid & Dec_branch & counter[index(Dec_pc)][1].
REQ-009 Ex_taken = Ex_valid & condition(Ex_type). Ex_mispredict = Ex_valid & (Ex_type!=0) & (Ex_taken != Ex_pred_taken).
REQ-010 Next-PC priority, highest first:
  (1) rst -> RESET_PC
  (2) Exception -> EXC_VECTOR
  (3) Ex_valid & Ex_jr -> Ex_a
  (4) Ex_mispredict -> Ex_target if Ex_taken, else Ex_pc+4
  (5) !Stall & Dec_valid & (Dec_jump | Pred_taken) -> Dec_target
  (6) Stall -> PC (hold)
  (7) otherwise PC+4
REQ-011 Flush_IF = 1 whenever a source (2)-(5) is selected.
REQ-012 Flush_ID = 1 whenever a source (2)-(4) is selected.
REQ-013 PC+4 and all targets wrap modulo 2^XLEN; no overflow flag.
REQ-014 BHT update on Ex_valid & Ex_type!=0, independent of Stall: increment on taken, decrement on not taken; saturate at 2'b11 and 2'b00.
REQ-015 BHT write takes effect the next cycle; a same-cycle read of the same index returns the old value (no bypass).
REQ-016 No BHT update while Exception=1.
REQ-017 Mispredict_cnt increments on each Ex_mispredict with Exception=0, and saturates at 16'hFFFF.
REQ-018 Redirect latency: the selected PC appears on PC exactly one cycle after the causing input.

Reset
REQ-019 On rst=1 at a clock edge:
  PC = RESET_PC
  all BHT counters = 2'b01 (weakly not taken)
  Mispredict_cnt = 0
REQ-020 rst overrides every other input, including mid-redirect. Flush_IF and Flush_ID read 0 while rst=1.

Structure
REQ-021 Package pc_pkg holds: branch-type encodings, counter-state constants, and the BHT index-width function.
REQ-022 Sub-module bht_2bit (parametrised BHT_DEPTH) holds the counter array with one read port and one write port; pc_branch_unit holds the PC register, condition logic and counter.

Verification
REQ-023 Reset release with defaults -> PC=0, then 4, 8, 12 on successive cycles; Mispredict_cnt=0.
REQ-024 Ex BEQ with a=b=5, pc=0x40, target=0x80, pred=0 -> next PC=0x80, Flush_IF=Flush_ID=1, Mispredict_cnt=1; counter[0] becomes 2'b10.
REQ-025 After REQ-024, Dec_branch at Dec_pc=0x40, target=0x80 -> Pred_taken=1, next PC=0x80, Flush_IF=1, Flush_ID=0.
REQ-026 BLTZ with a=-1, pred=1, repeated 4 times -> counter saturates at 2'b11, no mispredicts; BGEZ with a=0x8000_0000 and pred=1 -> redirect to Ex_pc+4.
REQ-027 In one cycle: Exception, Ex mispredict and Dec_jump all asserted -> PC=0x180, no BHT update, counter unchanged.
REQ-028 Stall=1 with Dec_jump=1 -> PC held, no flush; Stall=1 with Ex mispredict -> redirect still taken.
